// File: rtl/axis_tx.sv
// AXI-Stream byte transmitter: serialises AEROUT spike events and controller read-back words into host frames.
// Optional macro AXIS_TX_TIMESTAMP_EN adds a 16-bit push timestamp to every AER frame.
module axis_tx #(
    parameter int AER_W      = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    input  logic [AER_W-1:0] AEROUT_ADDR,
    input  logic             AEROUT_REQ,
    output logic             AEROUT_ACK,
    input  logic             CTRL_RD_VALID,
    input  logic [15:0]      CTRL_RD_DATA,
    output logic             FIFO_OVERFLOW,
    output logic             RB_OVERRUN
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef AXIS_TX_TIMESTAMP_EN
    localparam int ENT_W = AER_W + 16;
    localparam int IDX_W = 3;
    localparam int FRM_W = 32;
    localparam logic [IDX_W-1:0] AER_LAST = IDX_W'(3);
`else
    localparam int ENT_W = AER_W;
    localparam int IDX_W = 2;
    localparam int FRM_W = 24;
    localparam logic [IDX_W-1:0] AER_LAST = IDX_W'(1);
`endif
    localparam logic [IDX_W-1:0] RB_LAST  = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W+1)'(1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   last_idx;
    logic [FRM_W-1:0]   frame;
    logic [FRM_W-1:0]   aer_frame;
    logic [FRM_W-1:0]   rb_frame;

    logic [ENT_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;
    logic [PTR_W:0]     wr_ptr_p1;
    logic [ENT_W-1:0]   push_ent;
    logic [ENT_W-1:0]   pop_ent;
    logic [9:0]         pop_addr;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    logic               rb_pending;
    logic [15:0]        rb_data;
    logic               load_rb;
    logic               advance;

    assign FIFO_OVERFLOW = 1'b0;

    // The read side sees the write pointer one cycle late, giving the fixed first-word latency.
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty = (wr_ptr_p1 == rd_ptr);

    assign load_rb = (state == IDLE) && rb_pending;
    assign pop     = (state == IDLE) && !rb_pending && !empty;
    assign push    = !AEROUT_ACK && AEROUT_REQ && (!full || pop);
    assign advance = (state == SEND) && m_axis_tvalid && m_axis_tready;

    assign pop_ent  = mem[rd_ptr[PTR_W-1:0]];
    assign pop_addr = 10'(pop_ent[AER_W-1:0]);

`ifdef AXIS_TX_TIMESTAMP_EN
    logic [15:0] ts_cnt;

    always_ff @(posedge clk) begin
        if (rst) ts_cnt <= 16'd0;
        else     ts_cnt <= ts_cnt + 16'd1;
    end

    assign push_ent  = {ts_cnt, AEROUT_ADDR};
    assign aer_frame = {4'b0011, 2'b00, pop_addr[9:8], pop_addr[7:0], pop_ent[ENT_W-1 -: 16]};
    assign rb_frame  = {8'h40, rb_data, 8'h00};
`else
    assign push_ent  = AEROUT_ADDR;
    assign aer_frame = {4'b0010, 2'b00, pop_addr[9:8], pop_addr[7:0], 8'h00};
    assign rb_frame  = {8'h40, rb_data};
`endif

    // Four-phase acknowledge: ACK only rises on an accepted push, so each REQ pulse pushes once.
    always_ff @(posedge clk) begin
        if (rst)                          AEROUT_ACK <= 1'b0;
        else if (push)                    AEROUT_ACK <= 1'b1;
        else if (AEROUT_ACK && !AEROUT_REQ) AEROUT_ACK <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wr_ptr_p1 <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            wr_ptr_p1 <= wr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= push_ent;
    end

    // A new word arriving on the cycle the slot is loaded stays pending without counting as overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_pending <= 1'b0;
            RB_OVERRUN <= 1'b0;
        end else if (CTRL_RD_VALID) begin
            rb_pending <= 1'b1;
            if (rb_pending && !load_rb) RB_OVERRUN <= 1'b1;
        end else if (load_rb) begin
            rb_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (CTRL_RD_VALID) rb_data <= CTRL_RD_DATA;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            m_axis_tvalid <= 1'b0;
            idx           <= '0;
            last_idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_rb || pop) begin
                        last_idx      <= load_rb ? RB_LAST : AER_LAST;
                        idx           <= '0;
                        m_axis_tvalid <= 1'b1;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    if (advance) begin
                        if (idx == last_idx) begin
                            m_axis_tvalid <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            idx <= idx + IDX_ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (load_rb)      frame <= rb_frame;
        else if (pop)     frame <= aer_frame;
        else if (advance) frame <= frame << 8;
    end

    assign m_axis_tdata = m_axis_tvalid ? frame[FRM_W-1 -: 8] : 8'h00;
    assign m_axis_tlast = m_axis_tvalid && (idx == last_idx);

endmodule

// File: tb/tb_axis_tx.sv
// Bench for axis_tx: directed scenarios with random addresses/data/back-pressure against a byte-queue model.
module tb_axis_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [9:0]  AEROUT_ADDR;
    logic        AEROUT_REQ;
    logic        AEROUT_ACK;
    logic        CTRL_RD_VALID;
    logic [15:0] CTRL_RD_DATA;
    logic        FIFO_OVERFLOW;
    logic        RB_OVERRUN;

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  rx_q[$];
    logic [15:0] cyc;
    logic [15:0] last_ts;
    logic        rand_ready = 1'b0;
    logic        hold = 1'b0;
    logic [8:0]  held;

    axis_tx #(.AER_W(10), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .AEROUT_ADDR(AEROUT_ADDR), .AEROUT_REQ(AEROUT_REQ), .AEROUT_ACK(AEROUT_ACK),
        .CTRL_RD_VALID(CTRL_RD_VALID), .CTRL_RD_DATA(CTRL_RD_DATA),
        .FIFO_OVERFLOW(FIFO_OVERFLOW), .RB_OVERRUN(RB_OVERRUN)
    );

    always #5 clk = ~clk;

    // Cycles elapsed since the last reset edge; the timestamp of a push is its value before that edge.
    always @(posedge clk) cyc <= rst ? 16'd0 : cyc + 16'd1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Collect every accepted byte and police AXI hold rules while the sink stalls.
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) check("axi_hold", {23'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {23'd0, 1'b1, held});
            if (m_axis_tvalid && m_axis_tready) rx_q.push_back({m_axis_tlast, m_axis_tdata});
            hold = m_axis_tvalid && !m_axis_tready;
            held = {m_axis_tlast, m_axis_tdata};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add_aer(input logic [9:0] a, input logic [15:0] ts);
        last_ts = ts;
`ifdef AXIS_TX_TIMESTAMP_EN
        exp_q.push_back({1'b0, 8'(8'h30 + a / 256)});
        exp_q.push_back({1'b0, 8'(a % 256)});
        exp_q.push_back({1'b0, 8'(ts / 256)});
        exp_q.push_back({1'b1, 8'(ts % 256)});
`else
        exp_q.push_back({1'b0, 8'(8'h20 + a / 256)});
        exp_q.push_back({1'b1, 8'(a % 256)});
`endif
    endfunction

    function automatic void add_rb(input logic [15:0] d);
        exp_q.push_back({1'b0, 8'h40});
        exp_q.push_back({1'b0, 8'(d / 256)});
        exp_q.push_back({1'b1, 8'(d % 256)});
    endfunction

    task automatic send_req(input logic [9:0] a, output logic [15:0] ts);
        int n;
        AEROUT_ADDR = a;
        AEROUT_REQ  = 1'b1;
        n = 0;
        while (AEROUT_ACK !== 1'b1 && n < 40) begin step(); n++; end
        check("ack_rise", {31'd0, AEROUT_ACK}, 32'd1);
        ts = cyc - 16'd1;
        AEROUT_REQ = 1'b0;
        n = 0;
        while (AEROUT_ACK !== 1'b0 && n < 40) begin step(); n++; end
        check("ack_fall", {31'd0, AEROUT_ACK}, 32'd0);
    endtask

    task automatic rb_pulse(input logic [15:0] d);
        CTRL_RD_VALID = 1'b1;
        CTRL_RD_DATA  = d;
        step();
        CTRL_RD_VALID = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (rx_q.size() < exp_q.size() && n < 2000) begin
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            n++;
        end
        m_axis_tready = 1'b1;
        repeat (6) step();
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < rx_q.size()) check({tag, "_byte"}, {23'd0, rx_q[i]}, {23'd0, exp_q[i]});
        exp_q.delete();
        rx_q.delete();
    endtask

    initial begin
        #800000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ts;
        logic [9:0]  a;
        logic [9:0]  b;
        logic [15:0] d;
        int          n;

        rst = 1'b1; AEROUT_REQ = 1'b0; AEROUT_ADDR = '0;
        CTRL_RD_VALID = 1'b0; CTRL_RD_DATA = '0; m_axis_tready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
        check("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
        check("rst_ack", {31'd0, AEROUT_ACK}, 32'd0);
        check("rst_ovf", {31'd0, FIFO_OVERFLOW}, 32'd0);
        check("rst_overrun", {31'd0, RB_OVERRUN}, 32'd0);
        repeat (2) step();

        // Single event, latency: ACK one edge after REQ, first byte three edges after.
        AEROUT_ADDR = 10'h2A5; AEROUT_REQ = 1'b1;
        step();
        check("lat_ack", {31'd0, AEROUT_ACK}, 32'd1);
        add_aer(10'h2A5, cyc - 16'd1);
        AEROUT_REQ = 1'b0;
        step();
        check("lat_tvalid_early", {31'd0, m_axis_tvalid}, 32'd0);
        check("lat_ack_low", {31'd0, AEROUT_ACK}, 32'd0);
        step();
        check("lat_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        check("lat_hdr", {24'd0, m_axis_tdata}, {24'd0, exp_q[0][7:0]});
        drain("single");

        // Back-pressure mid-frame: second byte held for ten stalled cycles.
        m_axis_tready = 1'b0;
        a = 10'($urandom_range(0, 1023));
        send_req(a, ts); add_aer(a, ts);
        n = 0;
        while (!m_axis_tvalid && n < 10) begin step(); n++; end
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold", {23'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {23'd0, 1'b1, exp_q[1]});
        end
        drain("backpressure");

        // FIFO full: one frame stuck in the transmitter, sixteen queued, the next REQ stalls.
        m_axis_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            a = 10'($urandom_range(0, 1023));
            send_req(a, ts); add_aer(a, ts);
        end
        b = 10'($urandom_range(0, 1023));
        AEROUT_ADDR = b; AEROUT_REQ = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("full_stall", {31'd0, AEROUT_ACK}, 32'd0);
        end
        m_axis_tready = 1'b1;
        n = 0;
        while (AEROUT_ACK !== 1'b1 && n < 40) begin step(); n++; end
        check("full_release", {31'd0, AEROUT_ACK}, 32'd1);
        add_aer(b, cyc - 16'd1);
        AEROUT_REQ = 1'b0;
        step(); step();
        drain("fifo_full");

        // Read-back has priority over queued events.
        m_axis_tready = 1'b0;
        a = 10'($urandom_range(0, 1023));
        send_req(a, ts); add_aer(a, ts);
        rb_pulse(16'hBEEF);
        a = 10'($urandom_range(0, 1023)); send_req(a, ts);
        b = 10'($urandom_range(0, 1023)); send_req(b, last_ts);
        add_rb(16'hBEEF);
        add_aer(a, ts);
        add_aer(b, last_ts);
        check("prio_no_overrun", {31'd0, RB_OVERRUN}, 32'd0);
        drain("priority");

        // Overrun: second word replaces the first while a frame is in flight.
        m_axis_tready = 1'b0;
        a = 10'($urandom_range(0, 1023));
        send_req(a, ts); add_aer(a, ts);
        rb_pulse(16'h1111);
        step();
        rb_pulse(16'h2222);
        step();
        check("overrun_flag", {31'd0, RB_OVERRUN}, 32'd1);
        add_rb(16'h2222);
        drain("overrun");

        // Random events under random back-pressure, then one idle read-back.
        rand_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = 10'($urandom_range(0, 1023));
            send_req(a, ts); add_aer(a, ts);
        end
        drain("random");
        rand_ready = 1'b0;
        d = 16'($urandom);
        rb_pulse(d); add_rb(d);
        drain("rb_idle");

        // Reset mid-frame after the first byte, with another event queued behind it.
        m_axis_tready = 1'b0;
        a = 10'($urandom_range(0, 1023)); send_req(a, ts);
        a = 10'($urandom_range(0, 1023)); send_req(a, ts);
        n = 0;
        while (!m_axis_tvalid && n < 10) begin step(); n++; end
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("mid_rst_ack", {31'd0, AEROUT_ACK}, 32'd0);
        check("mid_rst_overrun", {31'd0, RB_OVERRUN}, 32'd0);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("mid_rst_empty", {31'd0, m_axis_tvalid}, 32'd0);
        end
        exp_q.delete();
        rx_q.delete();
        a = 10'($urandom_range(0, 1023));
        send_req(a, ts); add_aer(a, ts);
        drain("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
